uart_tx: RTL and testbench

AXI4-Stream-to-serial UART transmitter, the transmit-side counterpart of the existing AXI4-Stream UART receiver. Accepts one DATA_WIDTH-bit word per handshake and drives it onto `txd` as an 8N1-style frame: start bit, data LSB first, optional even parity, one stop bit. Bit timing uses the same `prescale` convention as the receiver, so both ends share one configuration register.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_bit_timer.sv | 43 ++++
 rtl/uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_t      : frame state encoding. ST_PARITY exists only when
//                         UART_TX_PARITY_EN is defined.
//   - PRESCALE_SHIFT    : bit period is prescale << PRESCALE_SHIFT clocks.
//   - BIT_TIMER_WIDTH   : width of the per-bit down-counter (16 + 3).
//   - bit_cnt_width()   : width needed to count data bits of one frame.
//   - even_parity()     : XOR of a (zero-extended) data word.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } uart_state_t;
`endif

    localparam int PRESCALE_SHIFT  = 3;
    localparam int BIT_TIMER_WIDTH = 19;

    // Bits needed to hold DATA_WIDTH-1 (the first value of the down-counting bit index).
    function automatic int bit_cnt_width(input int data_width);
        if (data_width <= 1) begin
            return 1;
        end else begin
            return $clog2(data_width);
        end
    endfunction

    // Even parity of up to 9 data bits; unused upper bits must be zero.
    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit period generator for the UART transmitter.
//   start    in  1  : load a new bit period from prescale (also latches it)
//   prescale in 16  : effective prescale P (already clamped to >= 1)
//   tick     out 1  : high in the final clock of every bit period
//   pre_tick out 1  : high one clock before tick
// The period P*8 is captured on start, so prescale may change afterwards
// without disturbing the frame in flight. The counter reloads itself at
// every tick, giving back-to-back bit periods.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] prescale,
    output logic        tick,
    output logic        pre_tick
);

    logic [BIT_TIMER_WIDTH-1:0] reload;
    logic [BIT_TIMER_WIDTH-1:0] count;
    logic [BIT_TIMER_WIDTH-1:0] period_m1;

    assign period_m1 = (BIT_TIMER_WIDTH'(prescale) << PRESCALE_SHIFT) - BIT_TIMER_WIDTH'(1);
    assign tick      = (count == {BIT_TIMER_WIDTH{1'b0}});
    assign pre_tick  = (count == BIT_TIMER_WIDTH'(1));

    // Period latch and down-counter with automatic reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= {BIT_TIMER_WIDTH{1'b0}};
            count  <= {BIT_TIMER_WIDTH{1'b0}};
        end else if (start) begin
            reload <= period_m1;
            count  <= period_m1;
        end else if (tick) begin
            count  <= reload;
        end else begin
            count  <= count - BIT_TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: AXI4-Stream to serial UART transmitter.
//   DATA_WIDTH    param   : data bits per frame (5..9)
//   clk, rst      in      : clock, asynchronous active-high reset
//   s_axis_tdata  in  DW  : word to send
//   s_axis_tvalid in  1   : tdata valid
//   s_axis_tready out 1   : word accepted this cycle when tvalid is high
//   txd           out 1   : serial line, idle high
//   busy          out 1   : frame in progress
//   prescale      in  16  : bit period is max(prescale,1)*8 clocks
// Frame: start(0), data LSB first, optional even parity, stop(1).
// Define UART_TX_PARITY_EN to insert the even-parity bit.
// All outputs are registers computed from the next-state logic. tready is
// raised in the last stop cycle so a waiting word starts without idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);

    localparam int BCW = bit_cnt_width(DATA_WIDTH);

    uart_state_t           state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [BCW-1:0]        bitcnt, bitcnt_next;
    logic                  txd_next, busy_next, tready_next;
    logic                  accept, timer_start, tick, pre_tick;
    logic [15:0]           p_eff;
`ifdef UART_TX_PARITY_EN
    logic                  par, par_next;
`endif

    assign accept = s_axis_tvalid && s_axis_tready;
    assign p_eff  = (prescale == 16'd0) ? 16'd1 : prescale;

    uart_bit_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (timer_start),
        .prescale (p_eff),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // Next-state, shift-register and registered-output logic.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        bitcnt_next = bitcnt;
        txd_next    = txd;
        busy_next   = busy;
        tready_next = 1'b0;
        timer_start = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next    = par;
`endif
        // Acceptance only happens in IDLE or in the last stop cycle.
        if (accept) begin
            shreg_next  = s_axis_tdata;
            bitcnt_next = BCW'(DATA_WIDTH - 1);
            timer_start = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_next    = even_parity(9'(s_axis_tdata));
`endif
        end else begin
            timer_start = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_START;
                    txd_next    = 1'b0;
                    busy_next   = 1'b1;
                    tready_next = 1'b0;
                end else begin
                    txd_next    = 1'b1;
                    busy_next   = 1'b0;
                    tready_next = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                    txd_next   = shreg[0];
                end else begin
                    txd_next   = 1'b0;
                end
            end
            ST_DATA: begin
                // shreg[0] always holds the bit currently on the line.
                if (tick) begin
                    if (bitcnt == {BCW{1'b0}}) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
                        txd_next   = par;
`else
                        state_next = ST_STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        shreg_next  = shreg >> 1;
                        bitcnt_next = bitcnt - BCW'(1);
                        txd_next    = shreg[1];
                    end
                end else begin
                    txd_next = shreg[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                    txd_next   = 1'b1;
                end else begin
                    txd_next   = par;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (accept) begin
                        state_next  = ST_START;
                        txd_next    = 1'b0;
                        busy_next   = 1'b1;
                        tready_next = 1'b0;
                    end else begin
                        state_next  = ST_IDLE;
                        txd_next    = 1'b1;
                        busy_next   = 1'b0;
                        tready_next = 1'b1;
                    end
                end else begin
                    // Open the input for exactly the final stop cycle.
                    txd_next    = 1'b1;
                    tready_next = pre_tick;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                txd_next    = 1'b1;
                busy_next   = 1'b0;
                tready_next = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg         <= {DATA_WIDTH{1'b0}};
            bitcnt        <= {BCW{1'b0}};
            txd           <= 1'b1;
            busy          <= 1'b0;
            s_axis_tready <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            shreg         <= shreg_next;
            bitcnt        <= bitcnt_next;
            txd           <= txd_next;
            busy          <= busy_next;
            s_axis_tready <= tready_next;
`ifdef UART_TX_PARITY_EN
            par           <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (DATA_WIDTH = 8).
// A frame-level model (bit list + elapsed-cycle count) predicts txd, busy
// and tready each cycle; directed tests add literal expectations.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [15:0] prescale = 16'd1;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits in line order: start, data LSB first, [parity], stop.
    function automatic logic [11:0] frame_of(input logic [7:0] d);
        logic [11:0] f;
        f = 12'hFFF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_txd, m_busy, m_ready, m_in;
    int          m_el = 0, m_per = 8, m_len = 80, m_acc = 0;
    logic [11:0] m_bits = 12'hFFF;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in <= 1'b0; m_txd <= 1'b1; m_busy <= 1'b0; m_ready <= 1'b0; m_el <= 0;
        end else begin
            logic in_n;
            int el_n, per_n, len_n;
            logic [11:0] bits_n;
            in_n = m_in; el_n = m_el; per_n = m_per; len_n = m_len; bits_n = m_bits;
            if (in_n) begin
                el_n = el_n + 1;
                if (el_n >= len_n) in_n = 1'b0;
            end
            if (s_axis_tvalid && m_ready) begin
                per_n  = ((prescale == 16'd0) ? 1 : int'(prescale)) * 8;
                len_n  = FB * per_n;
                bits_n = frame_of(s_axis_tdata);
                el_n   = 0;
                in_n   = 1'b1;
                m_acc <= m_acc + 1;
            end
            m_in <= in_n; m_el <= el_n; m_per <= per_n; m_len <= len_n; m_bits <= bits_n;
            m_busy  <= in_n;
            m_txd   <= in_n ? bits_n[el_n / per_n] : 1'b1;
            m_ready <= in_n ? (el_n == len_n - 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_txd", {31'd0, txd}, {31'd0, m_txd});
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_tready", {31'd0, s_axis_tready}, {31'd0, m_ready});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic hist_txd [0:2047];
    logic hist_busy[0:2047];
    logic hist_rdy [0:2047];
    int ev_drop = -1, ev_on = -1, ev_dat_i = -1, ev_pres_i = -1;
    logic [7:0]  ev_dat  = 8'h00;
    logic [15:0] ev_pres = 16'd1;

    // Present d and wait (bounded) until the model sees it accepted.
    task automatic send(input logic [7:0] d, input bit hold);
        int a0, t;
        a0 = m_acc;
        t = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (m_acc == a0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (t >= 2000) begin
            bad++;
            $display("FAIL send_timeout actual=%0d required=<2000", t);
        end
        if (!hold) s_axis_tvalid = 1'b0;
    endtask

    // Record n cycles (index 0 = first cycle of the accepted frame).
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hist_txd[i]  = txd;
            hist_busy[i] = busy;
            hist_rdy[i]  = s_axis_tready;
            if (i == ev_drop)   s_axis_tvalid = 1'b0;
            if (i == ev_on)     s_axis_tvalid = 1'b1;
            if (i == ev_dat_i)  s_axis_tdata  = ev_dat;
            if (i == ev_pres_i) prescale      = ev_pres;
        end
        ev_drop = -1; ev_on = -1; ev_dat_i = -1; ev_pres_i = -1;
    endtask

    function automatic int cnt_busy(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(hist_busy[i]);
        return c;
    endfunction

    function automatic int cnt_rdy(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) c += int'(hist_rdy[i]);
        return c;
    endfunction

    logic [11:0] f55;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        // Reset values
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", {31'd0, s_axis_tready}, 32'd1);

        // Single word 0x55, prescale 1
`ifdef UART_TX_PARITY_EN
        f55 = 12'h4AA;
`else
        f55 = 12'h2AA;
`endif
        prescale = 16'd1;
        send(8'h55, 1'b0);
        watch(FB * 8 + 4);
        chk("w55_busy_cycles", cnt_busy(0, FB * 8 + 3), FB * 8);
        chk("w55_busy_end", {31'd0, hist_busy[FB*8]}, 32'd0);
        for (int k = 0; k < FB; k++)
            chk("w55_bit", {31'd0, hist_txd[8*k+4]}, {31'd0, f55[k]});

        // Back-to-back 0xA5 then 0x3C, prescale 2
        prescale = 16'd2;
        send(8'hA5, 1'b1);
        ev_dat_i = 0; ev_dat = 8'h3C; ev_drop = FB * 16;
        watch(FB * 32 + 10);
        chk("b2b_rdy_last_stop", {31'd0, hist_rdy[FB*16-1]}, 32'd1);
        chk("b2b_rdy_before", {31'd0, hist_rdy[FB*16-2]}, 32'd0);
        chk("b2b_rdy_after", {31'd0, hist_rdy[FB*16]}, 32'd0);
        chk("b2b_rdy_pulses", cnt_rdy(0, FB * 16 - 1), 1);
        chk("b2b_busy_cycles", cnt_busy(0, FB * 32 + 9), FB * 32);
        chk("b2b_second_start", {31'd0, hist_txd[FB*16]}, 32'd0);
        chk("b2b_first_stop", {31'd0, hist_txd[FB*16-1]}, 32'd1);

        // Parity (or stop bit) position after data: 0x07 then 0x03
        prescale = 16'd1;
        send(8'h07, 1'b0);
        watch(FB * 8 + 4);
        chk("p07_bit9", {31'd0, hist_txd[76]}, 32'd1);
        chk("p07_len", cnt_busy(0, FB * 8 + 3), FB * 8);
        send(8'h03, 1'b0);
        watch(FB * 8 + 4);
`ifdef UART_TX_PARITY_EN
        chk("p03_bit9", {31'd0, hist_txd[76]}, 32'd0);
`else
        chk("p03_bit9", {31'd0, hist_txd[76]}, 32'd1);
`endif

        // prescale 0 behaves as 1
        prescale = 16'd0;
        send(8'h0F, 1'b0);
        watch(FB * 8 + 4);
        chk("ps0_len", cnt_busy(0, FB * 8 + 3), FB * 8);
        chk("ps0_start", {31'd0, hist_txd[4]}, 32'd0);
        chk("ps0_d0", {31'd0, hist_txd[12]}, 32'd1);
        chk("ps0_d4", {31'd0, hist_txd[44]}, 32'd0);

        // prescale change mid-frame applies only to the next frame
        prescale = 16'd1;
        send(8'h81, 1'b0);
        ev_pres_i = 20; ev_pres = 16'd4;
        watch(FB * 8 + 4);
        chk("psm_len1", cnt_busy(0, FB * 8 + 3), FB * 8);
        send(8'h81, 1'b0);
        watch(FB * 32 + 4);
        chk("psm_len2", cnt_busy(0, FB * 32 + 3), FB * 32);
        chk("psm_start", {31'd0, hist_txd[16]}, 32'd0);
        chk("psm_d0", {31'd0, hist_txd[48]}, 32'd1);

        // Backpressure: tvalid raised mid-frame, tdata changes while waiting
        prescale = 16'd1;
        send(8'h12, 1'b0);
        s_axis_tdata = 8'h99;
        ev_on = 20; ev_dat_i = 40; ev_dat = 8'h66; ev_drop = FB * 8;
        watch(FB * 16 + 4);
        chk("bp_rdy_pulses", cnt_rdy(0, FB * 8 - 1), 1);
        chk("bp_rdy_last", {31'd0, hist_rdy[FB*8-1]}, 32'd1);
        chk("bp_no_gap", {31'd0, hist_busy[FB*8]}, 32'd1);
        chk("bp_d0", {31'd0, hist_txd[FB*8+12]}, 32'd0);
        chk("bp_d1", {31'd0, hist_txd[FB*8+20]}, 32'd1);

        // Reset during data bit 3 of 0x00
        send(8'h00, 1'b0);
        watch(35);
        chk("mr_txd_low", {31'd0, hist_txd[34]}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mr_txd", {31'd0, txd}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_tready", {31'd0, s_axis_tready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mr_tready_hold", {31'd0, s_axis_tready}, 32'd0);
        rst = 1'b0;
        send(8'hFF, 1'b0);
        watch(FB * 8 + 4);
        chk("ff_len", cnt_busy(0, FB * 8 + 3), FB * 8);
        chk("ff_start", {31'd0, hist_txd[4]}, 32'd0);
        chk("ff_d0", {31'd0, hist_txd[12]}, 32'd1);
`ifdef UART_TX_PARITY_EN
        chk("ff_bit9", {31'd0, hist_txd[76]}, 32'd0);
`else
        chk("ff_bit9", {31'd0, hist_txd[76]}, 32'd1);
`endif

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
